reg_shift_sequencer: RTL and testbench

//  Multi-cycle sequencer for ARM register-specified shifts (shift amount taken from Rs[7:0]).
//  The single-cycle operand-2 generator handles immediate rotates and immediate shift amounts only.

---
 rtl/reg_shift_sequencer.sv | 167 ++++++++++++++++
 tb/tb_reg_shift_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle sequencer for ARM register-specified shifts: iterates a STEP-bit
// shifter over the effective amount and returns operand-2 plus shifter carry-out.
module reg_shift_sequencer #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] rm,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  amount,
    input  logic        carry_in,
    input  logic        flush,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;
    localparam logic [5:0] STEP_W = 6'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic [1:0]  type_q, type_d;
    logic        carry_q, carry_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic        carry_out_q, carry_out_d;

    logic [5:0]  eff;
    logic [5:0]  n;
    logic [32:0] lsl_ext;
    logic [32:0] lsr_ext;
    logic [32:0] asr_ext;
    logic [31:0] ror_val;
    logic [31:0] step_val;
    logic        step_c;

    // Effective amount: shifts saturate at 33 (any larger amount gives the same
    // result and carry); rotates reduce mod 32 but keep a nonzero multiple as 32.
    always_comb begin
        eff = 6'd0;
        if (shift_type == SH_ROR) begin
            if (amount == 8'd0) begin
                eff = 6'd0;
            end else if (amount[4:0] == 5'd0) begin
                eff = 6'd32;
            end else begin
                eff = {1'b0, amount[4:0]};
            end
        end else begin
            eff = (amount > 8'd33) ? 6'd33 : amount[5:0];
        end
    end

    // One iteration; the extra bit beside the value catches the last bit shifted out.
    always_comb begin
        n        = (rem_q < STEP_W) ? rem_q : STEP_W;
        lsl_ext  = {1'b0, val_q} << n;
        lsr_ext  = {val_q, 1'b0} >> n;
        asr_ext  = $signed({val_q, 1'b0}) >>> n;
        ror_val  = (val_q >> n) | (val_q << (6'd32 - n));
        step_val = val_q;
        step_c   = carry_q;
        case (type_q)
            SH_LSL: begin
                step_val = lsl_ext[31:0];
                step_c   = lsl_ext[32];
            end
            SH_LSR: begin
                step_val = lsr_ext[32:1];
                step_c   = lsr_ext[0];
            end
            SH_ASR: begin
                step_val = asr_ext[32:1];
                step_c   = asr_ext[0];
            end
            default: begin
                step_val = ror_val;
                step_c   = ror_val[31];
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        type_d      = type_q;
        carry_d     = carry_q;
        rem_d       = rem_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    val_d   = rm;
                    type_d  = shift_type;
                    carry_d = carry_in;
                    rem_d   = eff;
                    state_d = (eff == 6'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    val_d   = step_val;
                    carry_d = step_c;
                    rem_d   = rem_q - n;
                    if (rem_q == n) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    result_d    = val_q;
                    carry_out_d = carry_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            val_q       <= 32'd0;
            type_q      <= SH_LSL;
            carry_q     <= 1'b0;
            rem_q       <= 6'd0;
            result_q    <= 32'd0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            type_q      <= type_d;
            carry_q     <= carry_d;
            rem_q       <= rem_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

    // During an unflushed DONE cycle the fresh value is presented directly;
    // otherwise the last committed result is held.
    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE) && !flush;
    assign result    = done ? val_q : result_q;
    assign carry_out = done ? carry_q : carry_out_q;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Directed bench for reg_shift_sequencer: STEP=8 instance for most vectors,
// STEP=1 instance for the long-latency case.
module tb_reg_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start1;
    logic [31:0] rm;
    logic [1:0]  shift_type;
    logic [7:0]  amount;
    logic        carry_in;
    logic        flush;

    logic        ready, busy, done, carry_out;
    logic [31:0] result;
    logic        ready1, busy1, done1, carry_out1;
    logic [31:0] result1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_shift_sequencer #(.STEP(8)) dut (
        .clk(clk), .rst(rst), .start(start), .rm(rm), .shift_type(shift_type),
        .amount(amount), .carry_in(carry_in), .flush(flush),
        .ready(ready), .busy(busy), .done(done), .result(result), .carry_out(carry_out)
    );

    reg_shift_sequencer #(.STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rm(rm), .shift_type(shift_type),
        .amount(amount), .carry_in(carry_in), .flush(flush),
        .ready(ready1), .busy(busy1), .done(done1), .result(result1), .carry_out(carry_out1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic [31:0] r, input logic [1:0] t, input logic [7:0] a,
                         input logic c);
        @(negedge clk);
        rm         = r;
        shift_type = t;
        amount     = a;
        carry_in   = c;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1) cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] r, input logic [1:0] t,
                          input logic [7:0] a, input logic c, input logic [31:0] exp_r,
                          input logic exp_c, input int exp_lat);
        int lat;
        issue(r, t, a, c);
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_r);
        check({tag, " carry"}, {31'd0, carry_out}, {31'd0, exp_c});
        $display("op %s: rm=0x%08h type=%0d amt=%0d cin=%0b -> result=0x%08h C=%0b lat=%0d",
                 tag, r, t, a, c, result, carry_out, lat);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
        check({tag, " ready after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int lat;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; flush = 1'b0;
        rm = 32'd0; shift_type = 2'b00; amount = 8'd0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {31'd0, ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset carry", {31'd0, carry_out}, 32'd0);
        check("reset ready1", {31'd0, ready1}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_op("lsl4",     32'h0000_0001, 2'b00, 8'd4,   1'b1, 32'h0000_0010, 1'b0, 2);
        run_op("lsr32",    32'h8000_0001, 2'b01, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 5);
        run_op("lsl200",   32'h8000_0001, 2'b00, 8'd200, 1'b0, 32'h0000_0000, 1'b0, 6);
        run_op("asr40",    32'h8000_0000, 2'b10, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1, 6);
        run_op("ror36",    32'h0000_00F1, 2'b11, 8'h24,  1'b1, 32'h1000_000F, 1'b0, 2);
        run_op("ror32",    32'h8000_0002, 2'b11, 8'h20,  1'b0, 32'h8000_0002, 1'b1, 5);
        run_op("lsl32",    32'h0000_0003, 2'b00, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 5);
        run_op("lsr1",     32'h0000_0003, 2'b01, 8'd1,   1'b0, 32'h0000_0001, 1'b1, 2);
        run_op("asr4",     32'h8000_0010, 2'b10, 8'd4,   1'b1, 32'hF800_0001, 1'b0, 2);
        run_op("lsl0",     32'h1234_5678, 2'b00, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1);
        run_op("lsr0",     32'h1234_5678, 2'b01, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1);
        run_op("asr0",     32'h8765_4321, 2'b10, 8'd0,   1'b1, 32'h8765_4321, 1'b1, 1);
        run_op("ror0",     32'h1234_5678, 2'b11, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1);

        // start while busy is ignored
        issue(32'h8000_0001, 2'b01, 8'd32, 1'b0);
        @(negedge clk);
        rm = 32'hDEAD_BEEF; shift_type = 2'b00; amount = 8'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        count_dones(15, cnt);
        check("busy start dones", 32'(cnt), 32'd1);
        check("busy start result", result, 32'h0000_0000);
        check("busy start carry", {31'd0, carry_out}, 32'd1);
        $display("op busy_start: dones=%0d result=0x%08h C=%0b", cnt, result, carry_out);

        run_op("ror8",     32'h1234_5678, 2'b11, 8'd8,   1'b1, 32'h7812_3456, 1'b0, 2);

        // flush in SHIFT
        issue(32'hFFFF_FFFF, 2'b00, 8'd32, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush shift ready", {31'd0, ready}, 32'd1);
        check("flush shift busy", {31'd0, busy}, 32'd0);
        count_dones(10, cnt);
        check("flush shift dones", 32'(cnt), 32'd0);
        check("flush shift result", result, 32'h7812_3456);
        check("flush shift carry", {31'd0, carry_out}, 32'd0);
        $display("op flush_shift: dones=%0d result=0x%08h C=%0b", cnt, result, carry_out);

        // flush in DONE
        issue(32'hAAAA_5555, 2'b00, 8'd0, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush done pulse", {31'd0, done}, 32'd0);
        check("flush done result", result, 32'h7812_3456);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush done ready", {31'd0, ready}, 32'd1);
        check("flush done held", result, 32'h7812_3456);
        check("flush done carry", {31'd0, carry_out}, 32'd0);
        $display("op flush_done: result=0x%08h C=%0b", result, carry_out);

        // flush and start together in IDLE: request dropped
        @(negedge clk);
        rm = 32'h0000_0001; shift_type = 2'b00; amount = 8'd4; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush idle busy", {31'd0, busy}, 32'd0);
        count_dones(6, cnt);
        check("flush idle dones", 32'(cnt), 32'd0);
        $display("op flush_idle: dones=%0d busy=%0b", cnt, busy);

        // reset mid-SHIFT
        issue(32'hF0F0_F0F0, 2'b01, 8'd32, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid rst ready", {31'd0, ready}, 32'd1);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        check("mid rst result", result, 32'd0);
        check("mid rst carry", {31'd0, carry_out}, 32'd0);
        count_dones(8, cnt);
        check("mid rst dones", 32'(cnt), 32'd0);
        $display("op mid_reset: ready=%0b result=0x%08h dones=%0d", ready, result, cnt);

        // STEP=1 instance, LSL 33
        @(negedge clk);
        rm = 32'h0000_0001; shift_type = 2'b00; amount = 8'd33; carry_in = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = 1;
        while (done1 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("step1 latency", 32'(lat), 32'd34);
        check("step1 result", result1, 32'd0);
        check("step1 carry", {31'd0, carry_out1}, 32'd0);
        $display("op step1_lsl33: result=0x%08h C=%0b lat=%0d", result1, carry_out1, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
